// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit: FSM encoding, reset PC default,
// and the j/jal/beq/bne opcodes that decode (and benches) key off instr[31:26].
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// Combinational next-PC select for the retiring instruction: jump > taken branch > pc+4.
// Zero latency; no handshake, the caller samples next_pc only on retirement.
module next_pc_logic (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr,
  input  logic        branch,
  input  logic        bnesig,
  input  logic        jsig,
  input  logic        jalsig,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] br_off;
  logic        br_taken;

  // Word offset, so sign-extend then scale by 4; the add wraps mod 2^32.
  assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign br_taken = (branch & zero) | (bnesig & ~zero);

  always_comb begin
    next_pc = pc_plus4;
    if (jsig | jalsig) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (br_taken) begin
      next_pc = pc_plus4 + br_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch FSM: requests imem at PC, holds the returned word until decode retires it.
// One FETCH cycle minimum (zero-wait ack supported); request held stable until imem_ack.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        bnesig,
  input  logic        jsig,
  input  logic        jalsig,
  input  logic        zero,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count
);

  fetch_state_t state_q, state_nxt;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  count_q;
  logic [31:0]  next_pc;
  logic         latch_instr;
  logic         retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // imem_ack only matters in FETCH and instr_ready only in HOLD.
  always_comb begin
    state_nxt   = state_q;
    latch_instr = 1'b0;
    retire      = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          latch_instr = 1'b1;
          state_nxt   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          retire    = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      if (latch_instr) begin
        instr_q <= imem_rdata;
      end
      if (retire) begin
        pc_q    <= next_pc;
        count_q <= count_q + 32'd1;
      end
    end
  end

  // Control bits reach next_pc_logic freely; they only land in PC on retire.
  next_pc_logic u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q[25:0]),
    .branch   (branch),
    .bnesig   (bnesig),
    .jsig     (jsig),
    .jalsig   (jalsig),
    .zero     (zero),
    .next_pc  (next_pc)
  );

  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for next-PC cases, hand sequences for
// reset/ack/ready corner cases. Inputs driven and outputs sampled on the falling edge.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch = 1'b0, bnesig = 1'b0, jsig = 1'b0, jalsig = 1'b0, zero = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch      (branch),
    .bnesig      (bnesig),
    .jsig        (jsig),
    .jalsig      (jalsig),
    .zero        (zero),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .instr_count (instr_count)
  );

  // ctl layout: {branch, bnesig, jsig, jalsig, zero}
  typedef struct {
    string       name;
    logic [31:0] start_pc;
    logic [31:0] word;
    logic [4:0]  ctl;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ctl(input logic [4:0] ctl);
    {branch, bnesig, jsig, jalsig, zero} = ctl;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    set_ctl(5'b0);
    @(negedge clk);
    reset = 1'b0;
    m_pc = RST_PC;
    m_cnt = '0;
  endtask

  task automatic wait_fetch(input string name);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_fetch_req"}, {31'b0, imem_req}, 32'd1);
  endtask

  task automatic fetch(input string name, input logic [31:0] word);
    wait_fetch(name);
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic retire(input logic [4:0] ctl);
    instr_ready = 1'b1;
    set_ctl(ctl);
    @(negedge clk);
    instr_ready = 1'b0;
    set_ctl(5'b0);
    m_cnt = m_cnt + 32'd1;
  endtask

  // Walks the PC to target using j (region-local) and plain retires to cross 256MB regions.
  task automatic goto_pc(input logic [31:0] target);
    logic [31:0] p4;
    do_reset();
    for (int i = 0; i < 40 && m_pc != target; i++) begin
      p4 = m_pc + 32'd4;
      if (p4[31:28] == target[31:28]) begin
        fetch("goto", {OP_J, target[27:2]});
        retire(5'b00100);
        m_pc = target;
      end else if (m_pc[27:0] == 28'hFFF_FFFC) begin
        fetch("goto", 32'h0);
        retire(5'b00000);
        m_pc = p4;
      end else begin
        fetch("goto", {OP_J, 26'h3FF_FFFF});
        retire(5'b00100);
        m_pc = {p4[31:28], 28'hFFF_FFFC};
      end
    end
  endtask

  initial begin
    vecs[0] = '{"plain",     32'h0000_0010, 32'h3C01_1234, 5'b00000, 32'h0000_0014};
    vecs[1] = '{"beq_taken", 32'h0000_0020, {OP_BEQ, 5'd1, 5'd2, 16'hFFFE}, 5'b10001, 32'h0000_001C};
    vecs[2] = '{"beq_not",   32'h0000_0020, {OP_BEQ, 5'd1, 5'd2, 16'hFFFE}, 5'b10000, 32'h0000_0024};
    vecs[3] = '{"bne_taken", 32'h0000_0100, {OP_BNE, 5'd0, 5'd0, 16'h0003}, 5'b01000, 32'h0000_0110};
    vecs[4] = '{"bne_not",   32'h0000_0100, {OP_BNE, 5'd0, 5'd0, 16'h0003}, 5'b01001, 32'h0000_0104};
    vecs[5] = '{"jal",       32'h4000_0000, {OP_JAL, 26'h000_0040}, 5'b00010, 32'h4000_0100};
    vecs[6] = '{"j_over_br", 32'h0000_0200, {OP_J, 26'h000_0123}, 5'b10101, 32'h0000_048C};
    vecs[7] = '{"wrap",      32'hFFFF_FFFC, 32'h0000_0000, 5'b00000, 32'h0000_0000};

    // Reset state, ack ignored in IDLE, zero-wait fetch.
    @(negedge clk);
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0;
    check("rst_req",   {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_pc",    pc_out, RST_PC);
    check("rst_pc4",   pc_plus4, RST_PC + 32'd4);
    @(negedge clk);
    imem_ack = 1'b0;
    check("f1_req",   {31'b0, imem_req}, 32'd1);
    check("f1_addr",  imem_addr, 32'h0);
    check("f1_instr", instr, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'h3C01_1234;
    @(negedge clk);
    imem_ack = 1'b0;
    check("f1_valid", {31'b0, instr_valid}, 32'd1);
    check("f1_word",  instr, 32'h3C01_1234);

    // HOLD ignores ack and control bits without instr_ready.
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    set_ctl(5'b10101);
    @(negedge clk);
    imem_ack = 1'b0;
    set_ctl(5'b0);
    check("hold_valid", {31'b0, instr_valid}, 32'd1);
    check("hold_instr", instr, 32'h3C01_1234);
    check("hold_pc",    pc_out, 32'h0);
    check("hold_count", instr_count, 32'd0);
    retire(5'b00000);
    check("ret1_addr",  imem_addr, 32'h4);
    check("ret1_count", instr_count, 32'd1);

    // Ack withheld 5 cycles; instr_ready in FETCH must not move PC.
    for (int i = 0; i < 5; i++) begin
      instr_ready = (i == 2);
      @(negedge clk);
      check("stall_req",   {31'b0, imem_req}, 32'd1);
      check("stall_addr",  imem_addr, 32'h4);
      check("stall_valid", {31'b0, instr_valid}, 32'd0);
      check("stall_count", instr_count, 32'd1);
    end
    instr_ready = 1'b0;
    fetch("stall", 32'h0000_0000);
    check("stall_pc", pc_out, 32'h4);

    // Reset mid-FETCH with a simultaneous ack.
    retire(5'b00000);
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b0;
    check("rfetch_req",   {31'b0, imem_req}, 32'd0);
    check("rfetch_valid", {31'b0, instr_valid}, 32'd0);
    check("rfetch_count", instr_count, 32'd0);
    check("rfetch_instr", instr, 32'd0);
    check("rfetch_pc",    pc_out, RST_PC);
    @(negedge clk);
    check("rfetch_req2",  {31'b0, imem_req}, 32'd1);
    check("rfetch_addr2", imem_addr, RST_PC);

    // Reset wins over a retirement in the same cycle.
    fetch("rret", {OP_J, 26'h000_0100});
    reset = 1'b1;
    instr_ready = 1'b1;
    jsig = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    instr_ready = 1'b0;
    jsig = 1'b0;
    check("rret_count", instr_count, 32'd0);
    check("rret_pc",    pc_out, RST_PC);
    check("rret_valid", {31'b0, instr_valid}, 32'd0);

    // Table-driven next-PC vectors.
    for (int k = 0; k < 8; k++) begin
      goto_pc(vecs[k].start_pc);
      wait_fetch(vecs[k].name);
      check({vecs[k].name, "_addr"}, imem_addr, vecs[k].start_pc);
      imem_ack = 1'b1;
      imem_rdata = vecs[k].word;
      @(negedge clk);
      imem_ack = 1'b0;
      check({vecs[k].name, "_valid"}, {31'b0, instr_valid}, 32'd1);
      check({vecs[k].name, "_instr"}, instr, vecs[k].word);
      check({vecs[k].name, "_pc"},    pc_out, vecs[k].start_pc);
      check({vecs[k].name, "_pc4"},   pc_plus4, vecs[k].start_pc + 32'd4);
      retire(vecs[k].ctl);
      check({vecs[k].name, "_req"},   {31'b0, imem_req}, 32'd1);
      check({vecs[k].name, "_next"},  imem_addr, vecs[k].exp_next);
      check({vecs[k].name, "_count"}, instr_count, m_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port: imem_addr  output  32  word-aligned fetch address (= current PC).
REQ-006 SHALL have port: imem_ack  input  1  imem_rdata valid this cycle.
REQ-007 SHALL have port: imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port: instr  output  32  held instruction; opcode field instr[31:26] drives decode.
REQ-009 SHALL have port: instr_valid  output  1  instr holds an unconsumed instruction.
REQ-010 SHALL have port: instr_ready  input  1  decode/execute retires the held instruction this cycle.
REQ-011 SHALL have port: branch, bnesig, jsig, jalsig  input  1 each  control-unit outputs for the held instruction.
REQ-012 SHALL have port: zero  input  1  ALU zero flag for the held instruction.
REQ-013 SHALL have port: pc_out  output  32  PC of the held instruction.
REQ-014 SHALL have port: pc_plus4  output  32  pc_out + 4 (link value for jal).
REQ-015 SHALL have port: instr_count  output  32  number of retired instructions.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, HOLD.
REQ-017 IDLE: imem_req=0, instr_valid=0; SHALL go to FETCH the next cycle unconditionally.
REQ-018 FETCH: imem_req=1, imem_addr=PC, held stable until ack; on imem_ack=1 SHALL latch imem_rdata into instr and go to HOLD; else stay in FETCH.
REQ-019 Zero-wait memory SHALL be supported: ack in the first FETCH cycle -> HOLD next cycle.
REQ-020 HOLD: imem_req=0, instr_valid=1; instr, pc_out stable until retirement.
REQ-021 Retirement = HOLD && instr_ready; on it: PC <= next PC, instr_count += 1 (wraps 2^32-1 -> 0), go to FETCH.
REQ-022 Next PC, priority order: jsig|jalsig -> {pc_plus4[31:28], instr[25:0], 2'b00}; (branch&zero)|(bnesig&~zero) -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-023 All PC arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFF_FFFC + 4 -> 0).
REQ-024 branch, bnesig, jsig, jalsig, zero SHALL be ignored outside the retirement cycle.
REQ-025 imem_ack SHALL be ignored in IDLE and HOLD.
REQ-026 instr_ready SHALL be ignored outside HOLD.
REQ-027 pc_plus4 SHALL be combinational from pc_out.

Reset
REQ-028 With reset=1 at a rising edge: state=IDLE, PC=RESET_PC, instr=0, instr_count=0, pc_out=RESET_PC.
REQ-029 Reset SHALL take precedence over every other event, including an ack or retirement in the same cycle.
REQ-030 Reset during an outstanding FETCH SHALL abandon it; imem_req=0 the cycle after the reset edge; the first request after reset uses RESET_PC.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding (2-bit), RESET_PC default, and the opcode constants for j/jal/beq/bne used by benches.
REQ-032 Next-PC computation SHALL be a combinational sub-module next_pc_logic (inputs pc_plus4, instr, control bits, zero; output 32-bit next PC).

Verification
REQ-033 Reset, then ack on first FETCH cycle with rdata=32'h3C01_1234 -> imem_addr=0, instr_valid=1 next cycle, instr=32'h3C01_1234.
REQ-034 Retire with no control bits at PC=0x10 -> next imem_addr=0x14, instr_count=1.
REQ-035 Held beq, imm=16'hFFFE, PC=0x20, branch=1, zero=1 -> next imem_addr=0x1C; same with zero=0 -> 0x24.
REQ-036 Held jal, instr[25:0]=26'h000_0040, PC=0x4000_0000, jalsig=1 -> next imem_addr=0x4000_0100; pc_plus4=0x4000_0004 during HOLD.
REQ-037 Ack withheld 5 cycles -> imem_req and imem_addr stable all 5 cycles; instr_ready pulsed in FETCH -> no PC change.
REQ-038 Reset asserted mid-FETCH together with ack -> IDLE, instr_valid=0, instr_count=0, next request at RESET_PC.
